reg_write_arbiter: RTL and testbench
====================================

// Module: reg_write_arbiter
// PURPOSE
//  Round-robin arbiter sharing write access to a bank of 16-bit load-enabled registers between requesters.
//  Each cycle it picks at most one pending request and latches that requester's address and data.
//  On the following cycle it drives a one-hot load strobe and the data bus to the register bank, and returns a grant.
//  Sits between requester blocks and the register instances; it holds no register contents itself.
// PARAMETERS
//  WIDTH   16  data width of each register / request
//  N_REQ   4   number of requesters (>=2)
//  N_REGS  4   number of registers in the bank (power of 2)
//  AW      2   register address width, log2(N_REGS)
// PORTS
//  clk       in   1            clock, rising edge
//  rst       in   1            asynchronous reset, active-high
//  en        in   1            1: arbitration enabled; 0: no new grants, pointer frozen
//  req       in   N_REQ        per-requester write request, level
//  req_addr  in   N_REQ*AW     target register per requester; slice i = [i*AW +: AW]
//  req_data  in   N_REQ*WIDTH  write data per requester; slice i = [i*WIDTH +: WIDTH]
//  gnt       out  N_REQ        one-hot grant; high for exactly 1 cycle while the write is issued
//  reg_load  out  N_REGS       one-hot load strobe to the register bank
//  reg_d     out  WIDTH        data bus to all registers in the bank
//  wr_count  out  16           number of writes issued; saturates at 16'hFFFF
// BEHAVIOUR
//  - Reset (async, rst=1): gnt=0, reg_load=0, reg_d=0, wr_count=0, priority pointer=0 (requester 0 highest priority).
//  - eligible[i] = req[i] & ~gnt[i]. A requester granted in this cycle is masked from this cycle's arbitration.
//  - Arbitration (combinational, cycle N): the winner is the first eligible index found searching ptr, ptr+1, ..., wrapping modulo N_REQ.
//  - At edge end of N, if en=1 and a winner w exists:
//    - gnt <= onehot(w)
//    - reg_load <= onehot(req_addr[w])
//    - reg_d <= req_data[w]
//    - ptr <= (w+1) mod N_REQ
//    - wr_count <= wr_count+1, held at 16'hFFFF once reached.
//  - Otherwise, at that edge: gnt <= 0, reg_load <= 0, reg_d holds its last value, ptr unchanged.
//  - Latency: req sampled in cycle N -> gnt/reg_load/reg_d valid in cycle N+1. Registers capture at the end of N+1.
//  - Throughput: at most 1 write per cycle overall, and at most 1 write per 2 cycles per requester.
//  - Requester handshake:
//    - Hold req, req_addr and req_data stable until gnt[i] is seen.
//    - In the cycle gnt[i] is high, the requester may keep req high with new data; this is a new request, eligible next cycle.
//  - No two gnt bits and no two reg_load bits are ever high together. gnt and reg_load are either both zero or both one-hot.
//  - Simultaneous requests to the same register from different requesters are serialized in round-robin order. The last granted write wins.
//  - en falling while a grant is outstanding: the already-registered grant/load completes in the next cycle. No further grants until en=1.
//  - rst asserted mid-write: load strobe drops immediately (async). The in-flight write is lost and is not counted.
//  - req dropped before grant: the request is withdrawn with no side effect.
// TESTING
//  1. Reset, then req=4'b0001, addr0=2, data0=16'h0014 -> next cycle gnt=0001, reg_load=0100, reg_d=0014, wr_count=1.
//  2. req=4'b1111 held continuously, distinct data per requester -> gnt sequence 0001,0010,0100,1000,0001; wr_count increments each cycle.
//  3. ptr=2 after a grant to 1, req=4'b0011 -> requester 0 granted before 1 (wrap-around); no double grant to one requester in consecutive cycles.
//  4. en=0 with req=4'b0110 for 3 cycles -> gnt=0, reg_load=0, wr_count unchanged; en=1 -> grant to requester 1 (ptr preserved).
//  5. Requesters 0 and 3 both target addr 1 (data 16'h006F, 16'h046D) -> two single-strobe writes in successive cycles, in round-robin order.
//  6. rst pulse in the cycle reg_load=0010 is high -> all outputs 0 within the same cycle; wr_count=0; next request is granted from requester 0.

Source files
------------

// File: rtl/reg_write_arbiter.sv
// Round-robin write arbiter for a bank of load-enabled registers.
// Latches the winning requester's address/data and issues a one-hot load strobe and grant one cycle later.
module reg_write_arbiter #(
   parameter int WIDTH  = 16,
   parameter int N_REQ  = 4,
   parameter int N_REGS = 4,
   parameter int AW     = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   en,
   input  logic [N_REQ-1:0]       req,
   input  logic [N_REQ*AW-1:0]    req_addr,
   input  logic [N_REQ*WIDTH-1:0] req_data,
   output logic [N_REQ-1:0]       gnt,
   output logic [N_REGS-1:0]      reg_load,
   output logic [WIDTH-1:0]       reg_d,
   output logic [15:0]            wr_count
);

   localparam int        PW      = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam logic [PW:0] N_REQ_W = (PW+1)'(N_REQ);

   logic [AW-1:0]     addr_arr [N_REQ];
   logic [WIDTH-1:0]  data_arr [N_REQ];

   logic [N_REQ-1:0]  gnt_q, gnt_d;
   logic [N_REGS-1:0] reg_load_q, reg_load_d;
   logic [WIDTH-1:0]  reg_d_q, reg_d_d;
   logic [15:0]       wr_count_q, wr_count_d;
   logic [PW-1:0]     ptr_q, ptr_d;

   logic [N_REQ-1:0]  eligible;
   logic [N_REQ-1:0]  rot;
   logic              found;
   logic [PW-1:0]     win;
   logic [PW:0]       sum;

   generate
      for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
         assign addr_arr[gi] = req_addr[gi*AW +: AW];
         assign data_arr[gi] = req_data[gi*WIDTH +: WIDTH];
      end
   endgenerate

   // Rotate eligibility so bit 0 is the current highest-priority requester,
   // then map the first set bit back to an absolute index modulo N_REQ.
   always_comb begin
      eligible = req & ~gnt_q;
      rot      = N_REQ'({eligible, eligible} >> ptr_q);
      found    = 1'b0;
      win      = '0;
      sum      = '0;
      for (int k = 0; k < N_REQ; k++) begin
         if (!found && rot[k]) begin
            found = 1'b1;
            sum   = {1'b0, ptr_q} + (PW+1)'(k);
            win   = (sum >= N_REQ_W) ? PW'(sum - N_REQ_W) : PW'(sum);
         end
      end
   end

   always_comb begin
      gnt_d      = '0;
      reg_load_d = '0;
      reg_d_d    = reg_d_q;
      ptr_d      = ptr_q;
      wr_count_d = wr_count_q;
      if (en && found) begin
         gnt_d[win]                = 1'b1;
         reg_load_d[addr_arr[win]] = 1'b1;
         reg_d_d                   = data_arr[win];
         ptr_d                     = (win == PW'(N_REQ-1)) ? '0 : win + PW'(1);
         if (wr_count_q != 16'hFFFF) begin
            wr_count_d = wr_count_q + 16'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         gnt_q      <= '0;
         reg_load_q <= '0;
         reg_d_q    <= '0;
         wr_count_q <= '0;
         ptr_q      <= '0;
      end else begin
         gnt_q      <= gnt_d;
         reg_load_q <= reg_load_d;
         reg_d_q    <= reg_d_d;
         wr_count_q <= wr_count_d;
         ptr_q      <= ptr_d;
      end
   end

   assign gnt      = gnt_q;
   assign reg_load = reg_load_q;
   assign reg_d    = reg_d_q;
   assign wr_count = wr_count_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter: grant order, latency, enable gating,
// same-register serialization and asynchronous reset during a write.
module tb_reg_write_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic [3:0]  req;
   logic [7:0]  req_addr;
   logic [63:0] req_data;
   logic [3:0]  gnt;
   logic [3:0]  reg_load;
   logic [15:0] reg_d;
   logic [15:0] wr_count;

   int checks   = 0;
   int failures = 0;

   reg_write_arbiter #(.WIDTH(16), .N_REQ(4), .N_REGS(4), .AW(2)) dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .req      (req),
      .req_addr (req_addr),
      .req_data (req_data),
      .gnt      (gnt),
      .reg_load (reg_load),
      .reg_d    (reg_d),
      .wr_count (wr_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic expect_out(input string tag, input logic [3:0] eg, input logic [3:0] el,
                             input logic [15:0] ed, input logic [15:0] ec);
      check({tag, "_gnt"}, 32'(gnt), 32'(eg));
      check({tag, "_reg_load"}, 32'(reg_load), 32'(el));
      check({tag, "_reg_d"}, 32'(reg_d), 32'(ed));
      check({tag, "_wr_count"}, 32'(wr_count), 32'(ec));
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      $display("t=%0t req=%b en=%b gnt=%b reg_load=%b reg_d=%h wr_count=%0d",
               $time, req, en, gnt, reg_load, reg_d, wr_count);
      check("onehot_pair",
            32'(($countones(gnt) <= 1) && ($countones(reg_load) <= 1) &&
                ((gnt == 4'b0) == (reg_load == 4'b0))), 32'd1);
   endtask

   task automatic set_req(input int i, input logic [1:0] a, input logic [15:0] d);
      req_addr[i*2 +: 2]   = a;
      req_data[i*16 +: 16] = d;
   endtask

   initial begin
      logic [3:0] eg;
      rst      = 1'b1;
      en       = 1'b1;
      req      = 4'b0;
      req_addr = '0;
      req_data = '0;
      repeat (2) @(posedge clk);
      #1;
      expect_out("reset", 4'b0, 4'b0, 16'h0, 16'd0);
      rst = 1'b0;

      // Single request: one-cycle latency to grant and strobe
      set_req(0, 2'd2, 16'h0014);
      req = 4'b0001;
      step();
      expect_out("t1", 4'b0001, 4'b0100, 16'h0014, 16'd1);
      req = 4'b0000;
      step();
      expect_out("t1_idle", 4'b0, 4'b0, 16'h0014, 16'd1);

      // Fresh reset, then all four requesting continuously
      #2 rst = 1'b1;
      #1 expect_out("t2_rst", 4'b0, 4'b0, 16'h0, 16'd0);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) set_req(i, 2'(i), 16'h1000 + 16'(i));
      req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         step();
         eg = 4'b0001 << (k % 4);
         expect_out($sformatf("t2_k%0d", k), eg, eg, 16'h1000 + 16'(k % 4), 16'(k + 1));
      end
      req = 4'b0000;
      step();
      expect_out("t2_idle", 4'b0, 4'b0, 16'h1000, 16'd5);

      // Pointer at 1: grant 1, then 0 and 1 alternate with wrap-around
      req = 4'b0010;
      step();
      expect_out("t3_g1", 4'b0010, 4'b0010, 16'h1001, 16'd6);
      req = 4'b0011;
      step();
      expect_out("t3_g0", 4'b0001, 4'b0001, 16'h1000, 16'd7);
      step();
      expect_out("t3_g1b", 4'b0010, 4'b0010, 16'h1001, 16'd8);
      step();
      expect_out("t3_g0b", 4'b0001, 4'b0001, 16'h1000, 16'd9);
      req = 4'b0000;
      step();
      expect_out("t3_idle", 4'b0, 4'b0, 16'h1000, 16'd9);

      // Enable low freezes grants and pointer
      en  = 1'b0;
      req = 4'b0110;
      for (int k = 0; k < 3; k++) begin
         step();
         expect_out($sformatf("t4_dis%0d", k), 4'b0, 4'b0, 16'h1000, 16'd9);
      end
      en = 1'b1;
      step();
      expect_out("t4_en", 4'b0010, 4'b0010, 16'h1001, 16'd10);
      req = 4'b0000;
      step();
      expect_out("t4_idle", 4'b0, 4'b0, 16'h1001, 16'd10);

      // Requesters 0 and 3 target the same register; pointer is at 2
      set_req(0, 2'd1, 16'h006F);
      set_req(3, 2'd1, 16'h046D);
      req = 4'b1001;
      step();
      expect_out("t5_r3", 4'b1000, 4'b0010, 16'h046D, 16'd11);
      req = 4'b0001;
      step();
      expect_out("t5_r0", 4'b0001, 4'b0010, 16'h006F, 16'd12);

      // Async reset while the strobe is high
      req = 4'b0000;
      #2 rst = 1'b1;
      #1 expect_out("t6_rst", 4'b0, 4'b0, 16'h0, 16'd0);
      #1 rst = 1'b0;
      set_req(1, 2'd3, 16'h0BEE);
      req = 4'b0011;
      step();
      expect_out("t6_after", 4'b0001, 4'b0010, 16'h006F, 16'd1);
      req = 4'b0000;
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
